// File: rtl/variable_pkg.sv
// Shared video timing constants for the 800x600@60 raster (40 MHz pixel clock),
// the vga_timing_t bundle that downstream draw stages pass between themselves,
// and a small inclusive range-compare helper.
package variable_pkg;

    localparam int CNT_W = 11;

    typedef logic [CNT_W-1:0] cnt_t;

    // Horizontal timing, in pixel clocks from the start of the line.
    localparam cnt_t HOR_BLANK_START = 11'd800;
    localparam cnt_t HOR_SYNC_START  = 11'd840;
    localparam cnt_t HOR_SYNC_END    = 11'd967;
    localparam cnt_t HOR_BLANK_END   = 11'd1055;

    // Vertical timing, in lines from the start of the frame.
    localparam cnt_t VER_BLANK_START = 11'd600;
    localparam cnt_t VER_SYNC_START  = 11'd601;
    localparam cnt_t VER_SYNC_END    = 11'd604;
    localparam cnt_t VER_BLANK_END   = 11'd627;

    localparam int H_TOTAL = int'(HOR_BLANK_END) + 1;
    localparam int V_TOTAL = int'(VER_BLANK_END) + 1;

    typedef struct packed {
        cnt_t vcount;
        logic vsync;
        logic vblnk;
        cnt_t hcount;
        logic hsync;
        logic hblnk;
    } vga_timing_t;

    function automatic logic in_range(input cnt_t val, input cnt_t lo, input cnt_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 800x600@60 raster timing generator. Counters, flags and strobes are all
// registered; flags are derived from the next counter values so every output
// describes the same pixel in the same cycle.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit wrapping frame counter.
module vga_timing
    import variable_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             frame_start
);

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             origin_nxt;

    // Next raster position: advance the column, wrap into the next line/frame.
    always_comb begin
        h_nxt = hcount + 1'b1;
        v_nxt = vcount;
        if (hcount == HOR_BLANK_END) begin
            h_nxt = '0;
            v_nxt = (vcount == VER_BLANK_END) ? '0 : vcount + 1'b1;
        end
    end

    assign origin_nxt = (h_nxt == '0) && (v_nxt == '0);

    // Horizontal counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  hcount <= '0;
        else if (en) hcount <= h_nxt;
    end

    // Vertical counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  vcount <= '0;
        else if (en) vcount <= v_nxt;
    end

    // Sync/blank flags and strobes; reset state describes pixel (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (en) begin
            hsync       <= in_range(h_nxt, HOR_SYNC_START, HOR_SYNC_END);
            vsync       <= in_range(v_nxt, VER_SYNC_START, VER_SYNC_END);
            hblnk       <= in_range(h_nxt, HOR_BLANK_START, HOR_BLANK_END);
            vblnk       <= in_range(v_nxt, VER_BLANK_START, VER_BLANK_END);
            line_start  <= (h_nxt == '0);
            frame_start <= origin_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame counter: counts entries into pixel (0,0), wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 frame_cnt <= '0;
        else if (en && origin_nxt)  frame_cnt <= frame_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed self-checking bench for vga_timing. Full frames are far too long to
// simulate here, so the counters are jumped near points of interest with
// force/release and then allowed to run naturally before anything is checked.
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync, vsync, hblnk, vblnk, line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblnk       (hblnk),
        .vblnk       (vblnk),
        .line_start  (line_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Move the raster position; flags catch up on the next enabled edge.
    task automatic jump(input logic [10:0] h, input logic [10:0] v);
        force dut.hcount = h;
        force dut.vcount = v;
        #1;
        release dut.hcount;
        release dut.vcount;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        step(2);
        n_checks++;
        if ({hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start} !==
            {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b, want 0 0 0 0 0 0 1 1",
                     hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        step(1);
        n_checks++;
        if (hcount !== 11'd1 || vcount !== 11'd0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge: h=%0d v=%0d fs=%b, want h=1 v=0 fs=0", hcount, vcount, frame_start);
        end
        step(499);
        n_checks++;
        if (hcount !== 11'd500) begin
            n_fail++;
            $display("FAIL reach_500: h=%0d, want 500", hcount);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start} !==
            {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b, want 0 0 0 0 0 0 1 1",
                     hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_hflags;
        int hs_cnt = 0;
        int hb_rise = -1;
        for (int i = 0; i < 1056; i++) begin
            n_checks++;
            if (hcount !== 11'(i) || vcount !== 11'd0 ||
                hblnk !== (i >= 800) || hsync !== (i >= 840 && i <= 967) ||
                line_start !== (i == 0) || frame_start !== (i == 0)) begin
                n_fail++;
                $display("FAIL line0_pixel %0d: h=%0d v=%0d hb=%b hs=%b ls=%b fs=%b",
                         i, hcount, vcount, hblnk, hsync, line_start, frame_start);
            end
            if (hsync === 1'b1) hs_cnt++;
            if (hblnk === 1'b1 && hb_rise < 0) hb_rise = i;
            step(1);
        end
        n_checks++;
        if (hs_cnt != 128) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d cycles, want 128", hs_cnt);
        end
        n_checks++;
        if (hb_rise != 800) begin
            n_fail++;
            $display("FAIL hblnk_rise: got %0d, want 800", hb_rise);
        end
        n_checks++;
        if (hcount !== 11'd0 || vcount !== 11'd1 || line_start !== 1'b1 ||
            frame_start !== 1'b0 || hblnk !== 1'b0) begin
            n_fail++;
            $display("FAIL line_wrap: h=%0d v=%0d ls=%b fs=%b hb=%b, want 0 1 1 0 0",
                     hcount, vcount, line_start, frame_start, hblnk);
        end
        step(1);
        n_checks++;
        if (line_start !== 1'b0 || hcount !== 11'd1) begin
            n_fail++;
            $display("FAIL line_strobe_width: ls=%b h=%0d, want ls=0 h=1", line_start, hcount);
        end
    endtask

    task automatic test_vflags;
        int vs_cycles = 0;
        int ev, eh;
        jump(11'd1050, 11'd598);
        step(6);
        for (int k = 0; k < 7 * 1056; k++) begin
            ev = 599 + k / 1056;
            eh = k % 1056;
            n_checks++;
            if (hcount !== 11'(eh) || vcount !== 11'(ev) ||
                vblnk !== (ev >= 600) || vsync !== (ev >= 601 && ev <= 604) ||
                hblnk !== (eh >= 800) || line_start !== (eh == 0)) begin
                n_fail++;
                $display("FAIL vregion_pixel (%0d,%0d): h=%0d v=%0d vb=%b vs=%b hb=%b ls=%b",
                         eh, ev, hcount, vcount, vblnk, vsync, hblnk, line_start);
            end
            if (vsync === 1'b1) vs_cycles++;
            step(1);
        end
        n_checks++;
        if (vs_cycles != 4 * 1056) begin
            n_fail++;
            $display("FAIL vsync_width: got %0d cycles, want 4224", vs_cycles);
        end
        jump(11'd1050, 11'd627);
        step(5);
        n_checks++;
        if (hcount !== 11'd1055 || vcount !== 11'd627 || vblnk !== 1'b1 || vsync !== 1'b0) begin
            n_fail++;
            $display("FAIL last_pixel: h=%0d v=%0d vb=%b vs=%b, want 1055 627 1 0",
                     hcount, vcount, vblnk, vsync);
        end
        step(1);
        n_checks++;
        if (hcount !== 11'd0 || vcount !== 11'd0 || vblnk !== 1'b0 || hblnk !== 1'b0 ||
            frame_start !== 1'b1 || line_start !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_wrap: h=%0d v=%0d vb=%b hb=%b fs=%b ls=%b, want 0 0 0 0 1 1",
                     hcount, vcount, vblnk, hblnk, frame_start, line_start);
        end
    endtask

    task automatic test_frame_period;
        int cnt = 0;
        int max_h = 0;
        int max_v = 0;
        jump(11'd1055, 11'd620);
        step(1);
        n_checks++;
        if (hcount !== 11'd0 || vcount !== 11'd621 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL period_start: h=%0d v=%0d fs=%b, want 0 621 0", hcount, vcount, frame_start);
        end
        while (frame_start !== 1'b1 && cnt < 10000) begin
            step(1);
            cnt++;
            if (int'(hcount) > max_h) max_h = int'(hcount);
            if (int'(vcount) > max_v) max_v = int'(vcount);
        end
        n_checks++;
        if (cnt != 7392) begin
            n_fail++;
            $display("FAIL frame_tail_length: got %0d cycles, want 7392", cnt);
        end
        n_checks++;
        if (max_h > 1055 || max_v > 627) begin
            n_fail++;
            $display("FAIL count_range: max h=%0d v=%0d, limits 1055 627", max_h, max_v);
        end
    endtask

    task automatic test_stall;
        jump(11'd1050, 11'd627);
        step(5);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_checks++;
            if ({hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start} !==
                {11'd1055, 11'd627, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold %0d: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b, want 1055 627 0 0 1 1 0 0",
                         i, hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start);
            end
        end
        en = 1'b1;
        step(1);
        n_checks++;
        if ({hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start} !==
            {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_resume: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b, want 0 0 0 0 0 0 1 1",
                     hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start);
        end
        en = 1'b0;
        step(3);
        n_checks++;
        if (hcount !== 11'd0 || frame_start !== 1'b1 || line_start !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_hold: h=%0d fs=%b ls=%b, want 0 1 1", hcount, frame_start, line_start);
        end
        en = 1'b1;
        step(1);
        n_checks++;
        if (hcount !== 11'd1 || frame_start !== 1'b0 || line_start !== 1'b0) begin
            n_fail++;
            $display("FAIL no_repulse: h=%0d fs=%b ls=%b, want 1 0 0", hcount, frame_start, line_start);
        end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_reset: got %0d, want 0", frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            jump(11'd1050, 11'd627);
            step(6);
        end
        n_checks++;
        if (frame_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL frame_cnt_three: got %0d, want 3", frame_cnt);
        end
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        jump(11'd1050, 11'd627);
        step(6);
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_wrap: got %0d, want 0", frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hflags();
        test_vflags();
        test_frame_period();
        test_stall();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates the 800x600@60 VGA raster timing from the 40 MHz pixel clock.
- Produces horizontal/vertical pixel counters, sync and blanking flags, and line/frame start strobes.
- Sits at the head of the video pipeline and feeds the background, rect and font draw stages.
- All timing constants come from variable_pkg; no geometry is hard-coded in the module.

Parameters:
- H_TOTAL, HOR_BLANK_END+1 (1056): pixel clocks per line.
- V_TOTAL, VER_BLANK_END+1 (628): lines per frame.
- CNT_W, 11: counter width; must satisfy 2**CNT_W >= max(H_TOTAL, V_TOTAL).

Ports:
- clk  in  1  40 MHz pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, all state holds.
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1.
- vcount  out  CNT_W  current line, 0..V_TOTAL-1.
- hsync  out  1  high while HOR_SYNC_START <= hcount <= HOR_SYNC_END.
- vsync  out  1  high while VER_SYNC_START <= vcount <= VER_SYNC_END.
- hblnk  out  1  high while hcount >= HOR_BLANK_START.
- vblnk  out  1  high while vcount >= VER_BLANK_START.
- line_start  out  1  one-cycle strobe, high when hcount == 0.
- frame_start  out  1  one-cycle strobe, high when hcount == 0 and vcount == 0.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - hcount = 0, vcount = 0.
  - hsync = vsync = hblnk = vblnk = 0.
  - line_start = 1, frame_start = 1, because the outputs describe pixel (0,0).
- Every output is a flop. Flags are computed from the next counter values, so flags and counters always describe the same pixel in the same cycle. There is no skew between count and flags.
- Counting, on each rising clk edge with en = 1:
  - If hcount == H_TOTAL-1: hcount wraps to 0.
    - If vcount == V_TOTAL-1, vcount wraps to 0; otherwise vcount increments by 1.
  - Otherwise hcount increments by 1 and vcount holds.
- en = 0: counters, flags and strobes all hold their values. Strobes are not re-pulsed on the cycle en returns high.
- Flag ranges are inclusive at both bounds:
  - hsync: 840..967.
  - vsync: 601..604.
  - hblnk: 800..1055.
  - vblnk: 600..627.
- Flags are positive-true. Any polarity inversion is done at the pad stage, not here.
- Frame length with en held high: exactly 1056 * 628 = 663168 cycles between successive frame_start pulses.
- Reset asserted mid-frame: all outputs return to their reset values immediately. The first rising edge after release with en = 1 produces hcount = 1, vcount = 0.
- Counters never exceed H_TOTAL-1 or V_TOTAL-1. Out-of-range states cannot be reached.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt, 16 bits.
  - Reset value 0.
  - Increments on each cycle where the next state is pixel (0,0) and en = 1.
  - Wraps from 65535 to 0.
  - Used by animation stages for frame-based timing.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Add CNT_W and the derived totals H_TOTAL/V_TOTAL to variable_pkg, beside the existing timing constants.
- Add to variable_pkg a packed struct vga_timing_t bundling {vcount, vsync, vblnk, hcount, hsync, hblnk}, so downstream stages pass one signal.
- No sub-module: a single module with a horizontal and a vertical counter process plus flag registers.

Test Plan:
- Reset check: assert rst_n = 0 mid-line at hcount = 500, with no clock edge.
  -> Outputs become hcount = 0, vcount = 0, all flags 0, frame_start = 1 asynchronously.
- Horizontal flag edges: run line 0.
  -> hblnk rises exactly at hcount = 800.
  -> hsync is high for hcount 840..967 (128 cycles).
  -> At hcount 1055 -> 0, vcount becomes 1 and line_start pulses for one cycle.
- Vertical flag edges: run to line 600.
  -> vblnk = 1 at vcount = 600.
  -> vsync = 1 only for vcount 601..604.
  -> vblnk = 0 again at vcount = 0 of the next frame.
- Frame period: run 2 frames with en = 1.
  -> frame_start pulses are exactly 663168 cycles apart, and no count ever exceeds 1055/627.
- Enable stall: drop en for 10 cycles at (1055, 627).
  -> All outputs hold for those 10 cycles.
  -> The first enabled edge afterwards gives (0,0) with frame_start = 1 for one cycle.
- With VGA_TIMING_FRAME_CNT_EN: run 3 frames.
  -> frame_cnt = 3.
  -> Preload via force to 65535; the next frame gives 0.
